// File: rtl/fp_mul_special_pipe_if.sv
// Operand/result bus between the multiplier core, the special-case resolver and writeback.
interface fp_mul_special_pipe_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [EXP_W-1:0] core_e;
    logic [MAN_W-1:0] core_m;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     res;
    logic [3:0]       flags;
    logic [3:0]       sticky;
    logic             clr_sticky;

    // Producer/consumer side: drives operands and result-ready
    modport master (
        output in_valid, a, b, core_e, core_m, out_ready, clr_sticky,
        input  in_ready, out_valid, res, flags, sticky
    );

    // Resolver side
    modport slave (
        input  in_valid, a, b, core_e, core_m, out_ready, clr_sticky,
        output in_ready, out_valid, res, flags, sticky
    );
endinterface

// File: rtl/fp_mul_special_pipe.sv
// Two-stage special-case resolver for the FP multiplier: NaN/Inf/zero/Inf*0/denormal
// handling with IEEE sign rules, per-result and sticky exception flags.
module fp_mul_special_pipe #(
    parameter int unsigned EXP_W    = 8,
    parameter int unsigned MAN_W    = 23,
    parameter bit          NAN_PROP = 1'b0,
    parameter bit          FTZ      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_mul_special_pipe_if.slave bus
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } cls_t;

    // Classify an unsigned {exp, man} field
    function automatic cls_t classify(input logic [W-2:0] x);
        cls_t c;
        logic e_zero;
        logic e_ones;
        logic m_zero;
        e_zero = (x[W-2:MAN_W] == '0);
        e_ones = (x[W-2:MAN_W] == '1);
        m_zero = (x[MAN_W-1:0] == '0);
        c.zero = e_zero && m_zero;
        c.inf  = e_ones && m_zero;
        c.nan  = e_ones && !m_zero;
        return c;
    endfunction

    // Stage registers
    logic             s1_valid_q, s1_valid_d;
    cls_t             a_cls_q, b_cls_q;
    logic             sgn_q;
    logic [W-1:0]     nan_cand_q;
    logic [EXP_W-1:0] core_e_q;
    logic [MAN_W-1:0] core_m_q;
    logic             s2_valid_q;
    logic [W-1:0]     res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       sticky_q, sticky_d;

    // Flow control and input-side classification
    logic         s2_ld_c, s1_adv_c, in_acc_c, out_hs_c;
    cls_t         a_cls_c, b_cls_c;
    logic [W-1:0] nan_sel_c, nan_cand_c;

    // Stage advance: S2 frees when empty or drained, S1 follows without bubbles
    always_comb begin
        s2_ld_c    = !s2_valid_q || bus.out_ready;
        s1_adv_c   = s1_valid_q && s2_ld_c;
        in_acc_c   = bus.in_valid && (!s1_valid_q || s1_adv_c);
        out_hs_c   = s2_valid_q && bus.out_ready;
        s1_valid_d = in_acc_c ? 1'b1 : (s1_adv_c ? 1'b0 : s1_valid_q);
    end

    assign bus.in_ready = !s1_valid_q || s1_adv_c;

    // Operand classification and quieted NaN payload (A wins if both are NaN)
    always_comb begin
        a_cls_c    = classify(bus.a[W-2:0]);
        b_cls_c    = classify(bus.b[W-2:0]);
        nan_sel_c  = a_cls_c.nan ? bus.a : bus.b;
        nan_cand_c = {nan_sel_c[W-1:MAN_W], 1'b1, nan_sel_c[MAN_W-2:0]};
    end

    // S1: capture classifications and core result of an accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_cls_q    <= '0;
            b_cls_q    <= '0;
            sgn_q      <= 1'b0;
            nan_cand_q <= '0;
            core_e_q   <= '0;
            core_m_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_acc_c) begin
                a_cls_q    <= a_cls_c;
                b_cls_q    <= b_cls_c;
                sgn_q      <= bus.a[W-1] ^ bus.b[W-1];
                nan_cand_q <= nan_cand_c;
                core_e_q   <= bus.core_e;
                core_m_q   <= bus.core_m;
            end
        end
    end

    // Priority resolution of the S1 beat: NaN, Inf*0, Inf, zero, overflow, FTZ, pass-through
    always_comb begin
        res_d   = {sgn_q, core_e_q, core_m_q};
        flags_d = {3'b000, (core_e_q == '0) && (core_m_q == '0)};
        if (a_cls_q.nan || b_cls_q.nan) begin
            res_d   = NAN_PROP ? nan_cand_q : QNAN;
            flags_d = 4'b0100;
        end else if ((a_cls_q.inf && b_cls_q.zero) || (a_cls_q.zero && b_cls_q.inf)) begin
            res_d   = QNAN;
            flags_d = 4'b1100;
        end else if (a_cls_q.inf || b_cls_q.inf) begin
            res_d   = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 4'b0010;
        end else if (a_cls_q.zero || b_cls_q.zero) begin
            res_d   = {sgn_q, {(W-1){1'b0}}};
            flags_d = 4'b0001;
        end else if (core_e_q == '1) begin
            res_d   = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 4'b0010;
        end else if (FTZ && (core_e_q == '0) && (core_m_q != '0)) begin
            res_d   = {sgn_q, {(W-1){1'b0}}};
            flags_d = 4'b0001;
        end
    end

    // S2: resolved result; held stable while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            flags_q    <= '0;
        end else if (s2_ld_c) begin
            s2_valid_q <= s1_valid_q;
            if (s1_adv_c) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

    // Sticky accumulation; a delivered beat's flags survive a coincident clear
    always_comb begin
        sticky_d = sticky_q;
        if (out_hs_c) begin
            sticky_d = bus.clr_sticky ? flags_q : (sticky_q | flags_q);
        end else if (bus.clr_sticky) begin
            sticky_d = '0;
        end
    end

    // Sticky register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.res       = res_q;
    assign bus.flags     = flags_q;
    assign bus.sticky    = sticky_q;
endmodule
